// File: rtl/sr_ff_checker.sv
// Reference model and checker for an SR flip-flop: predicts q one cycle ahead,
// flags mismatches and illegal s=r=1 inputs. All outputs registered; 1-cycle latency; no backpressure.
module sr_ff_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             clr,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             illegal,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    typedef enum logic {
        ST_CHECK   = 1'b0,
        ST_UNKNOWN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic               exp_q_q, exp_q_d;
    logic               exp_valid_q, exp_valid_d;
    logic               mismatch_q, mismatch_d;
    logic               illegal_q, illegal_d;
    logic               err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   ill_cnt_q, ill_cnt_d;

    always_comb begin
        state_d      = state_q;
        exp_q_d      = exp_q_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        ill_cnt_d    = ill_cnt_q;

        // Compare against the prediction made before this edge's model update.
        mismatch_d = (state_q == ST_CHECK) && (q != exp_q_q);
        illegal_d  = s && r;

        unique case ({s, r})
            2'b10: begin
                exp_q_d = 1'b1;
                state_d = ST_CHECK;
            end
            2'b01: begin
                exp_q_d = 1'b0;
                state_d = ST_CHECK;
            end
            2'b11: state_d = ST_UNKNOWN;
            default: ;
        endcase

        exp_valid_d = (state_d == ST_CHECK);

        // Clear wins over same-edge detections; the pulses still fire.
        if (clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
            ill_cnt_d    = '0;
        end else begin
            if (mismatch_d) begin
                err_sticky_d = 1'b1;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
            if (illegal_d && (ill_cnt_q != CNT_MAX)) begin
                ill_cnt_d = ill_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CHECK;
            exp_q_q      <= 1'b0;
            exp_valid_q  <= 1'b1;
            mismatch_q   <= 1'b0;
            illegal_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            ill_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            exp_q_q      <= exp_q_d;
            exp_valid_q  <= exp_valid_d;
            mismatch_q   <= mismatch_d;
            illegal_q    <= illegal_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            ill_cnt_q    <= ill_cnt_d;
        end
    end

    assign exp_q      = exp_q_q;
    assign exp_valid  = exp_valid_q;
    assign mismatch   = mismatch_q;
    assign illegal    = illegal_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign ill_cnt    = ill_cnt_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed-vector bench for sr_ff_checker (CNT_W=2 so saturation is reachable);
// expected outputs are queued by the driver and popped by an independent monitor.
module tb_sr_ff_checker;

    localparam int CNT_W = 2;

    typedef struct packed {
        logic             eq;
        logic             ev;
        logic             mm;
        logic             il;
        logic             st;
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] ic;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst, s, r, q, clr;
    logic             exp_q, exp_valid, mismatch, illegal, err_sticky;
    logic [CNT_W-1:0] err_cnt, ill_cnt;

    resp_t exp_fifo[$];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    stim_done   = 1'b0;

    sr_ff_checker #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (s),
        .r          (r),
        .q          (q),
        .clr        (clr),
        .exp_q      (exp_q),
        .exp_valid  (exp_valid),
        .mismatch   (mismatch),
        .illegal    (illegal),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .ill_cnt    (ill_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic rst_v, input logic clr_v, input logic s_v,
                         input logic r_v, input logic q_v,
                         input logic eq, input logic ev, input logic mm,
                         input logic il, input logic st,
                         input logic [CNT_W-1:0] ec, input logic [CNT_W-1:0] ic);
        resp_t e;
        @(negedge clk);
        rst = rst_v; clr = clr_v; s = s_v; r = r_v; q = q_v;
        e.eq = eq; e.ev = ev; e.mm = mm; e.il = il; e.st = st; e.ec = ec; e.ic = ic;
        exp_fifo.push_back(e);
    endtask

    // Monitor: one response per clock edge, sampled just after the edge.
    initial begin : monitor
        resp_t act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_fifo.size() != 0) begin
                e = exp_fifo.pop_front();
                act.eq = exp_q; act.ev = exp_valid; act.mm = mismatch; act.il = illegal;
                act.st = err_sticky; act.ec = err_cnt; act.ic = ill_cnt;
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d: got eq=%b ev=%b mm=%b il=%b st=%b ec=%0d ic=%0d, want eq=%b ev=%b mm=%b il=%b st=%b ec=%0d ic=%0d",
                             vectors, act.eq, act.ev, act.mm, act.il, act.st, act.ec, act.ic,
                             e.eq, e.ev, e.mm, e.il, e.st, e.ec, e.ic);
                end
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1; clr = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0;
        //     rst clr s  r  q    eq ev mm il st ec ic
        apply(1, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0);  // reset state
        apply(0, 0, 1, 0, 0,     1, 1, 0, 0, 0, 0, 0);  // set, q correct
        apply(0, 0, 0, 0, 1,     1, 1, 0, 0, 0, 0, 0);  // hold, q follows
        apply(1, 0, 0, 0, 0,     0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1,     0, 1, 1, 0, 1, 1, 0);  // forced wrong q
        apply(0, 0, 0, 0, 0,     0, 1, 0, 0, 1, 1, 0);  // pulse is one cycle
        apply(0, 0, 1, 1, 0,     0, 0, 0, 1, 1, 1, 1);  // illegal -> UNKNOWN
        apply(0, 0, 0, 0, 1,     0, 0, 0, 0, 1, 1, 1);  // no compare in UNKNOWN
        apply(0, 0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 1);
        apply(0, 0, 0, 0, 1,     0, 0, 0, 0, 1, 1, 1);
        apply(0, 0, 0, 1, 1,     0, 1, 0, 0, 1, 1, 1);  // reset input leaves UNKNOWN
        apply(0, 0, 0, 0, 0,     0, 1, 0, 0, 1, 1, 1);
        apply(0, 0, 1, 1, 1,     0, 0, 1, 1, 1, 2, 2);  // both pulses together
        apply(0, 0, 1, 0, 0,     1, 1, 0, 0, 1, 2, 2);
        apply(0, 1, 0, 0, 0,     1, 1, 1, 0, 0, 0, 0);  // clr beats mismatch, model kept
        apply(0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 1, 0);  // saturation run
        apply(0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 2, 0);
        apply(0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 3, 0);
        apply(0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 3, 0);
        apply(0, 0, 0, 0, 0,     1, 1, 1, 0, 1, 3, 0);
        apply(0, 1, 1, 1, 1,     1, 0, 0, 1, 0, 0, 0);  // clr beats illegal count
        apply(0, 0, 1, 1, 0,     1, 0, 0, 1, 0, 0, 1);
        apply(0, 0, 1, 1, 1,     1, 0, 0, 1, 0, 0, 2);
        apply(0, 0, 1, 1, 0,     1, 0, 0, 1, 0, 0, 3);
        apply(0, 0, 1, 1, 1,     1, 0, 0, 1, 0, 0, 3);  // ill_cnt saturates
        apply(0, 0, 0, 1, 0,     0, 1, 0, 0, 0, 0, 3);
        apply(0, 0, 0, 0, 1,     0, 1, 1, 0, 1, 1, 3);
        apply(0, 0, 0, 0, 1,     0, 1, 1, 0, 1, 2, 3);
        apply(0, 0, 0, 0, 1,     0, 1, 1, 0, 1, 3, 3);
        apply(0, 0, 1, 1, 1,     0, 0, 1, 1, 1, 3, 3);  // UNKNOWN, err_cnt=3
        apply(1, 0, 1, 0, 1,     0, 1, 0, 0, 0, 0, 0);  // rst beats s and counting
        apply(1, 1, 1, 1, 1,     0, 1, 0, 0, 0, 0, 0);  // rst beats illegal and clr
        apply(0, 0, 1, 0, 0,     1, 1, 0, 0, 0, 0, 0);
        stim_done = 1'b1;
    end

    initial begin : finisher
        int guard;
        guard = 0;
        while (!stim_done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        if (!stim_done || exp_fifo.size() != 0) begin
            miscompares++;
            $display("FAIL drain: stim_done=%b pending=%0d, want stim_done=1 pending=0",
                     stim_done, exp_fifo.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
